// File: rtl/cci_mpf_quiesce_pkg.sv
// Shared types and defaults for the AFU-side quiesce (drain) sequencer.
package cci_mpf_quiesce_pkg;

  localparam int unsigned QUIESCE_STABLE_CYCLES_DFLT  = 4;
  localparam int unsigned QUIESCE_TIMEOUT_CYCLES_DFLT = 65536;
  localparam logic [15:0] QUIESCE_FENCE_MDATA_DFLT    = 16'hFE5C;

  typedef enum logic [2:0] {
    IDLE,
    BLOCK,
    FENCE,
    WAIT_RSP,
    WAIT_EMPTY,
    DONE
  } t_quiesce_state;

  // Width helper behind the t_stable_cnt / t_wdog_cnt typedefs: enough bits to hold
  // max_val itself, so a counter can sit at its terminal value without wrapping.
  function automatic int unsigned quiesce_cnt_width(input int unsigned max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/cci_mpf_quiesce_ctrl_if.sv
// Drain control, AFU issue monitor, c1 fence path and channel-occupancy signals.
// master: the drain requester / shim side; slave: the quiesce controller.
interface cci_mpf_quiesce_ctrl_if;

  logic        drain_req;
  logic        drain_busy;
  logic        drain_done;
  logic        drain_timeout;
  logic        afu_issue_block;
  logic        afu_c0_req_valid;
  logic        afu_c1_req_valid;
  logic        issue_violation;
  logic        c1TxAlmFull;
  logic        c1_wrfence_valid;
  logic [15:0] c1_wrfence_mdata;
  logic        c1_fence_rsp;
  logic [15:0] c1_rsp_mdata;
  logic        c0NotEmpty;
  logic        c1NotEmpty;

  modport master (
    output drain_req,
    input  drain_busy,
    input  drain_done,
    input  drain_timeout,
    input  afu_issue_block,
    output afu_c0_req_valid,
    output afu_c1_req_valid,
    input  issue_violation,
    output c1TxAlmFull,
    input  c1_wrfence_valid,
    input  c1_wrfence_mdata,
    output c1_fence_rsp,
    output c1_rsp_mdata,
    output c0NotEmpty,
    output c1NotEmpty
  );

  modport slave (
    input  drain_req,
    output drain_busy,
    output drain_done,
    output drain_timeout,
    output afu_issue_block,
    input  afu_c0_req_valid,
    input  afu_c1_req_valid,
    output issue_violation,
    input  c1TxAlmFull,
    output c1_wrfence_valid,
    output c1_wrfence_mdata,
    input  c1_fence_rsp,
    input  c1_rsp_mdata,
    input  c0NotEmpty,
    input  c1NotEmpty
  );

endinterface

// File: rtl/cci_mpf_prim_wdog.sv
// Loadable down-counter watchdog. expire_o flags the enabled cycle in which the count
// steps from 1 to 0; the count then parks at 0 until reloaded.
module cci_mpf_prim_wdog #(
  parameter int unsigned Width = 17
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             en_i,
  output logic             expire_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  // Next count: load has priority, otherwise decrement while enabled, never wrap.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  assign expire_o = en_i && !load_i && (cnt_q == Width'(1));

  // Count register, synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cci_mpf_quiesce_ctrl.sv
// AFU-side drain sequencer: blocks AFU issue, sends one c1 write fence, waits for its
// tagged response and for both channels to stay empty, then reports done. A watchdog
// aborts a stuck sequence.
module cci_mpf_quiesce_ctrl
  import cci_mpf_quiesce_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES  = QUIESCE_STABLE_CYCLES_DFLT,
  parameter int unsigned TIMEOUT_CYCLES = QUIESCE_TIMEOUT_CYCLES_DFLT,
  parameter logic [15:0] FENCE_MDATA    = QUIESCE_FENCE_MDATA_DFLT
) (
  input logic                   clk,
  input logic                   reset,
  cci_mpf_quiesce_ctrl_if.slave bus
);

  localparam int unsigned StableW = quiesce_cnt_width(STABLE_CYCLES);
  localparam int unsigned WdogW   = quiesce_cnt_width(TIMEOUT_CYCLES);

  typedef logic [StableW-1:0] t_stable_cnt;
  typedef logic [WdogW-1:0]   t_wdog_cnt;

  localparam t_stable_cnt StableLast = t_stable_cnt'(STABLE_CYCLES - 1);
  localparam t_stable_cnt StableMax  = t_stable_cnt'(STABLE_CYCLES);
  localparam t_wdog_cnt   WdogLoad   = t_wdog_cnt'(TIMEOUT_CYCLES);

  t_quiesce_state state_q, state_d;
  t_stable_cnt    stable_q, stable_d;

  logic busy_q, busy_d;
  logic block_q, block_d;
  logic done_q, done_d;
  logic timeout_q, timeout_d;
  logic fence_q, fence_d;
  logic viol_q, viol_d;

  logic accept;
  logic rsp_match;
  logic all_empty;
  logic wdog_en;
  logic wdog_expire;
  logic abort;

  assign accept    = (state_q == IDLE) && bus.drain_req;
  assign rsp_match = bus.c1_fence_rsp && (bus.c1_rsp_mdata == FENCE_MDATA);
  assign all_empty = !bus.c0NotEmpty && !bus.c1NotEmpty;
  assign wdog_en   = (state_q != IDLE);

  cci_mpf_prim_wdog #(
    .Width (WdogW)
  ) u_wdog (
    .clk        (clk),
    .reset      (reset),
    .load_i     (accept),
    .load_val_i (WdogLoad),
    .en_i       (wdog_en),
    .expire_o   (wdog_expire)
  );

  // State register plus registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      stable_q  <= '0;
      busy_q    <= 1'b0;
      block_q   <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      fence_q   <= 1'b0;
      viol_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      stable_q  <= stable_d;
      busy_q    <= busy_d;
      block_q   <= block_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      fence_q   <= fence_d;
      viol_q    <= viol_d;
    end
  end

  // Next-state logic; watchdog expiry aborts unless the drain is completing anyway.
  always_comb begin
    state_d = state_q;
    abort   = 1'b0;
    unique case (state_q)
      IDLE:       if (bus.drain_req) state_d = BLOCK;
      // One cycle so a request issued alongside acceptance shows up in NotEmpty.
      BLOCK:      state_d = FENCE;
      FENCE:      if (!bus.c1TxAlmFull) state_d = WAIT_RSP;
      WAIT_RSP:   if (rsp_match) state_d = WAIT_EMPTY;
      WAIT_EMPTY: if (all_empty && (stable_q == StableLast)) state_d = DONE;
      DONE:       state_d = IDLE;
      default:    state_d = IDLE;
    endcase
    if (wdog_expire && (state_q != DONE) && (state_d != DONE)) begin
      abort   = 1'b1;
      state_d = IDLE;
    end
  end

  // Stable-empty counter: runs only in WAIT_EMPTY, so it is zero on entry; saturates.
  always_comb begin
    stable_d = '0;
    if ((state_q == WAIT_EMPTY) && all_empty) begin
      stable_d = (stable_q == StableMax) ? stable_q : stable_q + 1'b1;
    end
  end

  // Output next values, registered alongside the state.
  always_comb begin
    busy_d    = (state_d != IDLE);
    block_d   = (state_d != IDLE);
    done_d    = (state_d == DONE);
    timeout_d = abort;
    fence_d   = (state_q == FENCE) && (state_d == WAIT_RSP);
    viol_d    = accept ? 1'b0
              : (viol_q | (block_q & (bus.afu_c0_req_valid | bus.afu_c1_req_valid)));
  end

  assign bus.drain_busy       = busy_q;
  assign bus.afu_issue_block  = block_q;
  assign bus.drain_done       = done_q;
  assign bus.drain_timeout    = timeout_q;
  assign bus.c1_wrfence_valid = fence_q;
  assign bus.c1_wrfence_mdata = FENCE_MDATA;
  assign bus.issue_violation  = viol_q;

endmodule

// File: tb/tb_cci_mpf_quiesce_ctrl.sv
// Directed bench for the quiesce sequencer. Two instances share all inputs: dut_a uses
// the default long watchdog, dut_b uses TIMEOUT_CYCLES=16 for the abort scenario.
// Cycle numbering: cycle 0 is the cycle drain_req is driven; outputs read in cycle k
// are the registered values after the k-th following clock edge.
module tb_cci_mpf_quiesce_ctrl;

  logic clk = 1'b0;
  logic reset;
  logic drain_req, c0_req, c1_req, alm_full, fence_rsp, c0_ne, c1_ne;
  logic [15:0] rsp_mdata;

  int n_checks = 0;
  int n_pass   = 0;

  // Per-run observations filled by run_drain.
  int a_fence_at, a_fence_cnt, a_done_at, a_done_cnt, a_busy_cnt, a_block_cnt;
  int a_viol_first, a_viol_end;
  int b_to_at, b_to_cnt, b_busy_cnt, b_block_cnt, b_done_cnt, b_fence_cnt;

  always #5 clk = ~clk;

  cci_mpf_quiesce_ctrl_if bus_a ();
  cci_mpf_quiesce_ctrl_if bus_b ();

  assign bus_a.drain_req        = drain_req;
  assign bus_a.afu_c0_req_valid = c0_req;
  assign bus_a.afu_c1_req_valid = c1_req;
  assign bus_a.c1TxAlmFull      = alm_full;
  assign bus_a.c1_fence_rsp     = fence_rsp;
  assign bus_a.c1_rsp_mdata     = rsp_mdata;
  assign bus_a.c0NotEmpty       = c0_ne;
  assign bus_a.c1NotEmpty       = c1_ne;
  assign bus_b.drain_req        = drain_req;
  assign bus_b.afu_c0_req_valid = c0_req;
  assign bus_b.afu_c1_req_valid = c1_req;
  assign bus_b.c1TxAlmFull      = alm_full;
  assign bus_b.c1_fence_rsp     = fence_rsp;
  assign bus_b.c1_rsp_mdata     = rsp_mdata;
  assign bus_b.c0NotEmpty       = c0_ne;
  assign bus_b.c1NotEmpty       = c1_ne;

  cci_mpf_quiesce_ctrl dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  cci_mpf_quiesce_ctrl #(
    .STABLE_CYCLES  (4),
    .TIMEOUT_CYCLES (16),
    .FENCE_MDATA    (16'hFE5C)
  ) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, $signed(got), $signed(exp));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    drain_req = 1'b0;
    c0_req    = 1'b0;
    c1_req    = 1'b0;
    alm_full  = 1'b0;
    fence_rsp = 1'b0;
    rsp_mdata = 16'hFE5C;
    c0_ne     = 1'b0;
    c1_ne     = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // One drain sequence of n cycles. Event arguments are cycle numbers, -1 = never.
  // alm_last: almost-full high in cycles 0..alm_last.
  task automatic run_drain(input int n, input int alm_last, input int bad_rsp_at,
                           input int good_rsp_at, input int ne_at, input int c1req_at,
                           input int req2_at);
    a_fence_at = -1; a_fence_cnt = 0; a_done_at = -1; a_done_cnt = 0;
    a_busy_cnt = 0; a_block_cnt = 0; a_viol_first = -1; a_viol_end = -1;
    b_to_at = -1; b_to_cnt = 0; b_busy_cnt = 0; b_block_cnt = 0; b_done_cnt = 0;
    b_fence_cnt = 0;
    drain_req = 1'b1;
    alm_full  = (alm_last >= 0);
    for (int k = 1; k <= n; k++) begin
      tick();
      drain_req = (k == req2_at);
      alm_full  = (k <= alm_last);
      fence_rsp = (k == bad_rsp_at) || (k == good_rsp_at);
      rsp_mdata = (k == bad_rsp_at) ? 16'h0001 : 16'hFE5C;
      c0_ne     = (k == ne_at);
      c1_req    = (k == c1req_at);
      if (bus_a.c1_wrfence_valid) begin
        a_fence_cnt++;
        if (a_fence_at < 0) a_fence_at = k;
      end
      if (bus_a.drain_done) begin
        a_done_cnt++;
        if (a_done_at < 0) a_done_at = k;
      end
      if (bus_a.drain_busy) a_busy_cnt++;
      if (bus_a.afu_issue_block) a_block_cnt++;
      if (bus_a.issue_violation && (a_viol_first < 0)) a_viol_first = k;
      if (k == n) a_viol_end = int'(bus_a.issue_violation);
      if (bus_b.drain_timeout) begin
        b_to_cnt++;
        if (b_to_at < 0) b_to_at = k;
      end
      if (bus_b.drain_busy) b_busy_cnt++;
      if (bus_b.afu_issue_block) b_block_cnt++;
      if (bus_b.drain_done) b_done_cnt++;
      if (bus_b.c1_wrfence_valid) b_fence_cnt++;
    end
    clear_inputs();
  endtask

  initial begin
    #100000;
    $display("FAIL sim_timeout: bench still running at 100000, expected to be done");
    $fatal(1);
  end

  initial begin
    clear_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    // Reset state.
    check("rst_busy", 32'(bus_a.drain_busy), 0);
    check("rst_block", 32'(bus_a.afu_issue_block), 0);
    check("rst_done", 32'(bus_a.drain_done), 0);
    check("rst_timeout", 32'(bus_a.drain_timeout), 0);
    check("rst_fence", 32'(bus_a.c1_wrfence_valid), 0);
    check("rst_viol", 32'(bus_a.issue_violation), 0);
    check("fence_mdata", 32'(bus_a.c1_wrfence_mdata), 32'h0000FE5C);

    // 1: plain drain, response 2 cycles after the strobe (strobe 3, rsp 5);
    // done at 1+1+1+2+4+1 = 10. A second drain_req at cycle 6 is ignored.
    do_reset();
    run_drain(14, -1, -1, 5, -1, -1, 6);
    check("t1_fence_at", a_fence_at, 3);
    check("t1_fence_cnt", a_fence_cnt, 1);
    check("t1_done_at", a_done_at, 10);
    check("t1_done_cnt", a_done_cnt, 1);
    check("t1_busy_cnt", a_busy_cnt, 10);
    check("t1_block_cnt", a_block_cnt, 10);
    check("t1_no_viol", a_viol_first, -1);

    // 2: almost-full held through FENCE cycles 2..21; first low cycle 22 -> strobe 23,
    // rsp 25, empty 26..29, done 30.
    do_reset();
    run_drain(34, 21, -1, 25, -1, -1, -1);
    check("t2_fence_at", a_fence_at, 23);
    check("t2_fence_cnt", a_fence_cnt, 1);
    check("t2_done_at", a_done_at, 30);

    // 3: c0NotEmpty on the 3rd stable cycle (8); fresh clean cycles 9..12 -> done 13.
    do_reset();
    run_drain(16, -1, -1, 5, 8, -1, -1);
    check("t3_done_at", a_done_at, 13);
    check("t3_done_cnt", a_done_cnt, 1);

    // 4: dut_b, no response in time: busy in cycles 1..16, timeout visible in 17 with
    // busy/block low; a response at 20 arrives in IDLE and changes nothing.
    do_reset();
    run_drain(30, -1, -1, 20, -1, -1, -1);
    check("t4_to_at", b_to_at, 17);
    check("t4_to_cnt", b_to_cnt, 1);
    check("t4_busy_cnt", b_busy_cnt, 16);
    check("t4_block_cnt", b_block_cnt, 16);
    check("t4_done_cnt", b_done_cnt, 0);
    check("t4_fence_cnt", b_fence_cnt, 1);

    // 5: mdata 0x0001 response at 5 ignored; real one at 9 -> empty 10..13, done 14.
    do_reset();
    run_drain(18, -1, 5, 9, -1, -1, -1);
    check("t5_done_at", a_done_at, 14);
    check("t5_busy_cnt", a_busy_cnt, 14);

    // 6: AFU c1 request in FENCE (cycle 2) -> violation from 3, held past done.
    do_reset();
    run_drain(14, -1, -1, 5, -1, 2, -1);
    check("t6_viol_first", a_viol_first, 3);
    check("t6_viol_end", a_viol_end, 1);
    check("t6_done_at", a_done_at, 10);
    drain_req = 1'b1;
    tick();
    drain_req = 1'b0;
    check("t6_viol_cleared", 32'(bus_a.issue_violation), 0);
    check("t6_busy_again", 32'(bus_a.drain_busy), 1);
    for (int k = 2; k <= 7; k++) begin
      tick();
      fence_rsp = (k == 5);
    end
    // Cycle 7 is WAIT_EMPTY; reset here clears everything on the next cycle.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t6_rst_outs",
          32'({bus_a.drain_busy, bus_a.afu_issue_block, bus_a.drain_done,
               bus_a.drain_timeout, bus_a.c1_wrfence_valid, bus_a.issue_violation}), 0);
    fence_rsp = 1'b1;
    tick();
    fence_rsp = 1'b0;
    tick();
    check("t6_late_rsp_idle", 32'({bus_a.drain_busy, bus_a.drain_done}), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
